// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int PDATA_WIDTH        = 8;
  localparam int BAUD_SAMPLE_CYCLES = 16;

  typedef enum logic [1:0] {
    CHAR5 = 2'b00,
    CHAR6 = 2'b01,
    CHAR7 = 2'b10,
    CHAR8 = 2'b11
  } charl_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  // Number of data bits carried by a character of the given length code.
  function automatic logic [3:0] charl_to_len(input charl_t c);
    return 4'd5 + {2'b00, c};
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// RX FIFO write-port bundle between the deframer (master) and the
// receive FIFO (slave).
interface uart_rx_deframer_if #(
  parameter int PDATA_WIDTH = uart_pkg::PDATA_WIDTH
);
  import uart_pkg::*;

  logic                   rcvr_fifo_full;
  logic                   rx_wr;
  logic [PDATA_WIDTH-1:0] rx_data;
  logic                   rx_pe;
  logic                   rx_fe;
  logic                   rx_bi;
  logic                   rx_oe;

  modport master (
    input  rcvr_fifo_full,
    output rx_wr, rx_data, rx_pe, rx_fe, rx_bi, rx_oe
  );

  modport slave (
    output rcvr_fifo_full,
    input  rx_wr, rx_data, rx_pe, rx_fe, rx_bi, rx_oe
  );

endinterface

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line plus a
// one-cycle falling-edge pulse derived from the synchronized value.
// All flops reset to 1 so a line held idle never produces a spurious edge.
module uart_rx_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain and one extra stage for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversamples sRX with a 16x baud-tick enable,
// strips start/parity/stop bits and writes right-justified characters with
// parity/framing/break status into the RX FIFO, flagging overrun when full.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit decision becomes a
// 2-of-3 vote over three consecutive tick samples, decided on the third.
module uart_rx_deframer #(
  parameter int PDATA_WIDTH        = uart_pkg::PDATA_WIDTH,
  parameter int BAUD_SAMPLE_CYCLES = uart_pkg::BAUD_SAMPLE_CYCLES
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      baud_tick,
  input  logic                      sRX,
  input  logic [1:0]                lcr_charl,
  input  logic                      lcr_stop,
  input  logic                      lcr_par_en,
  input  logic                      lcr_par_sel,
  output logic                      rx_busy,
  uart_rx_deframer_if.master        rx_if
);
  import uart_pkg::*;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE_EXTRA = 1;
`else
  localparam int VOTE_EXTRA = 0;
`endif

  localparam int CNT_W     = $clog2(BAUD_SAMPLE_CYCLES + 2);
  localparam int IDX_W     = $clog2(PDATA_WIDTH);
  // Tick count at which the start bit is judged (mid-bit).
  localparam int START_DEC = BAUD_SAMPLE_CYCLES / 2 + VOTE_EXTRA;
  // Tick count at which every later bit is judged, one bit period on.
  localparam int BIT_DEC   = BAUD_SAMPLE_CYCLES + VOTE_EXTRA;
  // Counter value after a decision; with voting the window is measured
  // from the decision tick, which sits one tick past the bit centre.
  localparam int RELOAD    = VOTE_EXTRA;

  // The receiver checks only the first stop bit whatever the stop setting.
  logic lcr_stop_unused;
  assign lcr_stop_unused = lcr_stop;

  logic rx_sync;
  logic rx_fall;

  uart_rx_sync_edge u_sync (
    .clk_i  (PCLK),
    .rst_ni (PRESETn),
    .async_i(sRX),
    .sync_o (rx_sync),
    .fall_o (rx_fall)
  );

  rx_state_t              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;
  logic [PDATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]       bit_idx_q;
  logic [IDX_W-1:0]       last_idx;
  charl_t                 charl_q;
  logic                   par_en_q;
  logic                   par_sel_q;
  logic                   par_bit_q;
  logic                   pe_q;
  logic                   busy_q;
  logic                   rx_wr_q;
  logic [PDATA_WIDTH-1:0] rx_data_q;
  logic                   rx_pe_q;
  logic                   rx_fe_q;
  logic                   rx_bi_q;
  logic                   rx_oe_q;
  logic                   sample_bit;
  logic                   start_done;
  logic                   bit_done;
  logic                   exp_par;
  logic                   brk;

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign start_done = (cnt_inc == CNT_W'(START_DEC));
  assign bit_done   = (cnt_inc == CNT_W'(BIT_DEC));
  assign last_idx   = IDX_W'(charl_to_len(charl_q) - 4'd1);
  // Even parity: the parity bit equals the XOR of the data bits.
  assign exp_par    = par_sel_q ? (^data_q) : ~(^data_q);
  // Break: all data zero, parity sample zero (cleared when unused), stop zero.
  assign brk        = (data_q == '0) && !par_bit_q && !sample_bit;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0]       vote_q;
  logic [CNT_W-1:0] dec_cnt;

  assign dec_cnt = (state_q == START) ? CNT_W'(START_DEC) : CNT_W'(BIT_DEC);

  // Capture the two samples that precede each decision tick.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      vote_q <= 2'b11;
    end else if (baud_tick &&
                 ((cnt_inc == dec_cnt - CNT_W'(2)) || (cnt_inc == dec_cnt - CNT_W'(1)))) begin
      vote_q <= {vote_q[0], rx_sync};
    end
  end

  assign sample_bit = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_sync) | (vote_q[0] & rx_sync);
`else
  assign sample_bit = rx_sync;
`endif

  // Frame FSM with registered FIFO-side outputs; all bit timing advances
  // only on baud_tick so a stalled tick freezes the frame in place.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      bit_idx_q <= '0;
      charl_q   <= CHAR5;
      par_en_q  <= 1'b0;
      par_sel_q <= 1'b0;
      par_bit_q <= 1'b0;
      pe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rx_wr_q   <= 1'b0;
      rx_data_q <= '0;
      rx_pe_q   <= 1'b0;
      rx_fe_q   <= 1'b0;
      rx_bi_q   <= 1'b0;
      rx_oe_q   <= 1'b0;
    end else begin
      rx_wr_q <= 1'b0;
      rx_oe_q <= 1'b0;
      rx_pe_q <= 1'b0;
      rx_fe_q <= 1'b0;
      rx_bi_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_fall) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            if (start_done) begin
              if (!sample_bit) begin
                charl_q   <= charl_t'(lcr_charl);
                par_en_q  <= lcr_par_en;
                par_sel_q <= lcr_par_sel;
                busy_q    <= 1'b1;
                cnt_q     <= CNT_W'(RELOAD);
                data_q    <= '0;
                bit_idx_q <= '0;
                par_bit_q <= 1'b0;
                pe_q      <= 1'b0;
                state_q   <= DATA;
              end else begin
                cnt_q   <= '0;
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_done) begin
              cnt_q             <= CNT_W'(RELOAD);
              data_q[bit_idx_q] <= sample_bit;
              if (bit_idx_q == last_idx) begin
                state_q <= par_en_q ? PARITY : STOP;
              end else begin
                bit_idx_q <= bit_idx_q + IDX_W'(1);
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            if (bit_done) begin
              cnt_q     <= CNT_W'(RELOAD);
              par_bit_q <= sample_bit;
              pe_q      <= (sample_bit != exp_par);
              state_q   <= STOP;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (bit_done) begin
              cnt_q <= '0;
              if (rx_if.rcvr_fifo_full) begin
                rx_oe_q <= 1'b1;
              end else begin
                rx_wr_q   <= 1'b1;
                rx_data_q <= data_q;
                rx_pe_q   <= pe_q;
                rx_fe_q   <= ~sample_bit;
                rx_bi_q   <= brk;
              end
              if (brk) begin
                state_q <= BRK_WAIT;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        BRK_WAIT: begin
          if (rx_sync) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_busy       = busy_q;
  assign rx_if.rx_wr   = rx_wr_q;
  assign rx_if.rx_data = rx_data_q;
  assign rx_if.rx_pe   = rx_pe_q;
  assign rx_if.rx_fe   = rx_fe_q;
  assign rx_if.rx_bi   = rx_bi_q;
  assign rx_if.rx_oe   = rx_oe_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: directed frames from the test
// plan plus randomized frames checked against a behavioural frame model.
module tb_uart_rx_deframer;
  import uart_pkg::*;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic       baud_tick = 1'b0;
  logic       sRX = 1'b1;
  logic [1:0] lcr_charl = 2'b11;
  logic       lcr_stop = 1'b0;
  logic       lcr_par_en = 1'b0;
  logic       lcr_par_sel = 1'b0;
  logic       rx_busy;

  uart_rx_deframer_if #(.PDATA_WIDTH(8)) rx_if ();

  uart_rx_deframer dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .baud_tick  (baud_tick),
    .sRX        (sRX),
    .lcr_charl  (lcr_charl),
    .lcr_stop   (lcr_stop),
    .lcr_par_en (lcr_par_en),
    .lcr_par_sel(lcr_par_sel),
    .rx_busy    (rx_busy),
    .rx_if      (rx_if)
  );

  always #5 PCLK = ~PCLK;

  int          div = 8;
  int          divcnt = 0;
  int unsigned cyc = 0;
  int unsigned tick_cnt = 0;
  int unsigned tick_cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Baud tick generator: one PCLK pulse every div cycles, changed on negedge.
  always @(negedge PCLK) begin
    if (divcnt >= div - 1) begin
      divcnt    <= 0;
      baud_tick <= 1'b1;
    end else begin
      divcnt    <= divcnt + 1;
      baud_tick <= 1'b0;
    end
  end

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (baud_tick) begin
      tick_cnt <= tick_cnt + 1;
      tick_cyc <= cyc + 1;
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        fe;
    logic        bi;
    logic        busy;
    int unsigned tk;
    int unsigned lat;
  } wr_t;

  wr_t wrq[$];
  int  oe_cnt = 0;
  int  oe_run = 0;
  int  oe_maxrun = 0;
  int  stray_flags = 0;
  int  busy_cycles = 0;

  // Output monitor, sampled on the inactive edge.
  always @(negedge PCLK) begin : mon
    wr_t w;
    if (rx_if.rx_wr === 1'b1) begin
      w.data = rx_if.rx_data;
      w.pe   = rx_if.rx_pe;
      w.fe   = rx_if.rx_fe;
      w.bi   = rx_if.rx_bi;
      w.busy = rx_busy;
      w.tk   = tick_cnt;
      w.lat  = cyc - tick_cyc;
      wrq.push_back(w);
    end else if (rx_if.rx_pe || rx_if.rx_fe || rx_if.rx_bi) begin
      stray_flags++;
    end
    if (rx_if.rx_oe === 1'b1) begin
      oe_run++;
      if (oe_run == 1) oe_cnt++;
      if (oe_run > oe_maxrun) oe_maxrun = oe_run;
    end else begin
      oe_run = 0;
    end
    if (rx_busy === 1'b1) busy_cycles++;
  end

  // Reference rule for the parity bit a correct transmitter would send.
  function automatic logic ref_par_bit(input logic [7:0] d, input logic even);
    int ones;
    ones = $countones(d);
    return even ? ((ones % 2) == 1) : ((ones % 2) == 0);
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge PCLK iff baud_tick);
    #1;
  endtask

  // Serialize one frame; LCR inputs are scrambled after the start bit is
  // judged, which the receiver must ignore.
  task automatic send_frame(input logic [7:0] d, input int len, input logic pen,
                            input logic psel, input logic pbit, input logic stopv,
                            output int unsigned t0);
    lcr_charl   = 2'(len - 5);
    lcr_par_en  = pen;
    lcr_par_sel = psel;
    lcr_stop    = 1'($urandom);
    wait_ticks(1);
    t0  = tick_cnt;
    sRX = 1'b0;
    wait_ticks(10);
    lcr_charl   = 2'($urandom);
    lcr_par_en  = 1'($urandom);
    lcr_par_sel = 1'($urandom);
    wait_ticks(6);
    for (int i = 0; i < len; i++) begin
      sRX = d[i];
      wait_ticks(16);
    end
    if (pen) begin
      sRX = pbit;
      wait_ticks(16);
    end
    sRX = stopv;
    wait_ticks(16);
    sRX = 1'b1;
  endtask

  task automatic test_reset();
    #2 PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    n_checks++;
    if ({rx_if.rx_wr, rx_if.rx_data, rx_if.rx_pe, rx_if.rx_fe, rx_if.rx_bi, rx_if.rx_oe, rx_busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {rx_if.rx_wr, rx_if.rx_data, rx_if.rx_pe, rx_if.rx_fe, rx_if.rx_bi, rx_if.rx_oe, rx_busy});
    end
    PRESETn = 1'b1;
    wait_ticks(40);
    n_checks++;
    if (wrq.size() != 0 || rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: writes %0d busy %b expected 0 and 0", wrq.size(), rx_busy);
    end
  endtask

  task automatic test_8n1();
    int unsigned t0;
    int bc;
    wr_t w;
    wrq.delete();
    bc = busy_cycles;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    n_checks++;
    if (wrq.size() != 1) begin
      n_fail++;
      $display("FAIL 8n1_count: got %0d writes expected 1", wrq.size());
    end else begin
      w = wrq.pop_front();
      n_checks++;
      if (w.data !== 8'hA5) begin
        n_fail++;
        $display("FAIL 8n1_data: got %h expected a5", w.data);
      end
      n_checks++;
      if ({w.pe, w.fe, w.bi} !== 3'b000) begin
        n_fail++;
        $display("FAIL 8n1_flags: got pe/fe/bi %b expected 000", {w.pe, w.fe, w.bi});
      end
      n_checks++;
      if (w.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL 8n1_busy_at_wr: got %b expected 0", w.busy);
      end
      n_checks++;
      if (w.tk != t0 + 8 + 16 * 9 || w.lat != 0) begin
        n_fail++;
        $display("FAIL 8n1_latency: got tick %0d lat %0d expected tick %0d lat 0", w.tk, w.lat, t0 + 8 + 16 * 9);
      end
    end
    n_checks++;
    if (busy_cycles - bc < 8 * 16 * div) begin
      n_fail++;
      $display("FAIL 8n1_busy_span: got %0d busy cycles expected at least %0d", busy_cycles - bc, 8 * 16 * div);
    end
  endtask

  task automatic test_parity5();
    int unsigned t0;
    wr_t w;
    for (int k = 0; k < 2; k++) begin
      wrq.delete();
      send_frame(8'h13, 5, 1'b1, 1'b1, (k == 0) ? 1'b1 : 1'b0, 1'b1, t0);
      n_checks++;
      if (wrq.size() != 1) begin
        n_fail++;
        $display("FAIL par5_count[%0d]: got %0d writes expected 1", k, wrq.size());
      end else begin
        w = wrq.pop_front();
        n_checks++;
        if (w.data !== 8'h13 || w.pe !== ((k == 0) ? 1'b0 : 1'b1) || w.fe !== 1'b0 || w.bi !== 1'b0) begin
          n_fail++;
          $display("FAIL par5_frame[%0d]: got data %h pe %b fe %b bi %b expected 13 pe %0d fe 0 bi 0",
                   k, w.data, w.pe, w.fe, w.bi, k);
        end
      end
    end
  endtask

  task automatic test_framing();
    int unsigned t0;
    wr_t w;
    wrq.delete();
    send_frame(8'h41, 7, 1'b1, 1'b0, ref_par_bit(8'h41, 1'b0), 1'b0, t0);
    wait_ticks(4);
    n_checks++;
    if (wrq.size() != 1) begin
      n_fail++;
      $display("FAIL fe_count: got %0d writes expected 1", wrq.size());
    end else begin
      w = wrq.pop_front();
      n_checks++;
      if (w.data !== 8'h41 || w.fe !== 1'b1 || w.bi !== 1'b0 || w.pe !== 1'b0) begin
        n_fail++;
        $display("FAIL fe_frame: got data %h pe %b fe %b bi %b expected 41 pe 0 fe 1 bi 0",
                 w.data, w.pe, w.fe, w.bi);
      end
    end
  endtask

  task automatic test_break();
    int unsigned t0;
    wr_t w;
    wrq.delete();
    lcr_charl = 2'b11; lcr_par_en = 1'b0; lcr_par_sel = 1'b0;
    wait_ticks(1);
    sRX = 1'b0;
    wait_ticks(320);
    n_checks++;
    if (wrq.size() != 1) begin
      n_fail++;
      $display("FAIL brk_count: got %0d writes expected 1", wrq.size());
    end else begin
      w = wrq.pop_front();
      n_checks++;
      if (w.data !== 8'h00 || w.bi !== 1'b1 || w.fe !== 1'b1 || w.pe !== 1'b0) begin
        n_fail++;
        $display("FAIL brk_frame: got data %h pe %b fe %b bi %b expected 00 pe 0 fe 1 bi 1",
                 w.data, w.pe, w.fe, w.bi);
      end
    end
    n_checks++;
    if (rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL brk_hold_busy: got %b expected 1", rx_busy);
    end
    sRX = 1'b1;
    wait_ticks(32);
    n_checks++;
    if (rx_busy !== 1'b0 || wrq.size() != 0) begin
      n_fail++;
      $display("FAIL brk_release: busy %b writes %0d expected 0 and 0", rx_busy, wrq.size());
    end
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    n_checks++;
    if (wrq.size() != 1) begin
      n_fail++;
      $display("FAIL brk_next_count: got %0d writes expected 1", wrq.size());
    end else begin
      w = wrq.pop_front();
      n_checks++;
      if (w.data !== 8'h3C || {w.pe, w.fe, w.bi} !== 3'b000) begin
        n_fail++;
        $display("FAIL brk_next_frame: got data %h flags %b expected 3c 000", w.data, {w.pe, w.fe, w.bi});
      end
    end
  endtask

  task automatic test_glitch_overrun();
    int unsigned t0;
    int bc, oc;
    wrq.delete();
    div = 64;
    wait_ticks(2);
    bc = busy_cycles;
    sRX = 1'b0;
    repeat (300) @(posedge PCLK);
    #1 sRX = 1'b1;
    wait_ticks(12);
    n_checks++;
    if (wrq.size() != 0 || busy_cycles != bc) begin
      n_fail++;
      $display("FAIL glitch: got %0d writes %0d busy cycles expected 0 and 0", wrq.size(), busy_cycles - bc);
    end
    oc = oe_cnt;
    oe_maxrun = 0;
    rx_if.rcvr_fifo_full = 1'b1;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    rx_if.rcvr_fifo_full = 1'b0;
    n_checks++;
    if (wrq.size() != 0) begin
      n_fail++;
      $display("FAIL ovr_no_write: got %0d writes expected 0", wrq.size());
    end
    n_checks++;
    if (oe_cnt - oc != 1 || oe_maxrun != 1) begin
      n_fail++;
      $display("FAIL ovr_pulse: got %0d pulses max width %0d expected 1 and 1", oe_cnt - oc, oe_maxrun);
    end
    div = 8;
    wait_ticks(4);
  endtask

  task automatic test_reset_midframe();
    int unsigned t0;
    wr_t w;
    wrq.delete();
    lcr_charl = 2'b11; lcr_par_en = 1'b0;
    wait_ticks(1);
    sRX = 1'b0;
    wait_ticks(16);
    sRX = 1'b1;
    wait_ticks(64);
    n_checks++;
    if (rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_busy_before: got %b expected 1", rx_busy);
    end
    #2 PRESETn = 1'b0;
    #1;
    n_checks++;
    if ({rx_if.rx_wr, rx_if.rx_data, rx_if.rx_pe, rx_if.rx_fe, rx_if.rx_bi, rx_if.rx_oe, rx_busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b expected all zero",
               {rx_if.rx_wr, rx_if.rx_data, rx_if.rx_pe, rx_if.rx_fe, rx_if.rx_bi, rx_if.rx_oe, rx_busy});
    end
    #23 PRESETn = 1'b1;
    wait_ticks(20);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, t0);
    n_checks++;
    if (wrq.size() != 1) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d writes expected 1", wrq.size());
    end else begin
      w = wrq.pop_front();
      n_checks++;
      if (w.data !== 8'h81 || {w.pe, w.fe, w.bi} !== 3'b000) begin
        n_fail++;
        $display("FAIL rstmid_frame: got data %h flags %b expected 81 000", w.data, {w.pe, w.fe, w.bi});
      end
    end
  endtask

  task automatic test_random();
    int unsigned t0;
    int len, oc;
    logic [7:0] d;
    logic pen, psel, pbit, stopv, full, epe, efe, ebi;
    wr_t w;
    for (int f = 0; f < 20; f++) begin
      wrq.delete();
      len   = $urandom_range(5, 8);
      d     = 8'($urandom) & 8'((1 << len) - 1);
      pen   = 1'($urandom);
      psel  = 1'($urandom);
      pbit  = ref_par_bit(d, psel) ^ ($urandom_range(0, 3) == 0);
      stopv = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) begin
        d = 8'h00; pbit = 1'b0; stopv = 1'b0;
      end
      full = ($urandom_range(0, 5) == 0);
      epe  = pen && (pbit != ref_par_bit(d, psel));
      efe  = !stopv;
      ebi  = (d == 8'h00) && (!pen || !pbit) && !stopv;
      oc   = oe_cnt;
      rx_if.rcvr_fifo_full = full;
      send_frame(d, len, pen, psel, pbit, stopv, t0);
      rx_if.rcvr_fifo_full = 1'b0;
      if (full) begin
        n_checks++;
        if (wrq.size() != 0 || oe_cnt - oc != 1) begin
          n_fail++;
          $display("FAIL rnd_ovr[%0d]: got %0d writes %0d oe expected 0 and 1", f, wrq.size(), oe_cnt - oc);
        end
      end else begin
        n_checks++;
        if (wrq.size() != 1) begin
          n_fail++;
          $display("FAIL rnd_count[%0d]: got %0d writes expected 1", f, wrq.size());
        end else begin
          w = wrq.pop_front();
          n_checks++;
          if (w.data !== d || w.pe !== epe || w.fe !== efe || w.bi !== ebi) begin
            n_fail++;
            $display("FAIL rnd_frame[%0d]: got data %h pe %b fe %b bi %b expected %h %b %b %b",
                     f, w.data, w.pe, w.fe, w.bi, d, epe, efe, ebi);
          end
          n_checks++;
          if (w.tk != t0 + 8 + 16 * (len + int'(pen) + 1) || w.lat != 0) begin
            n_fail++;
            $display("FAIL rnd_latency[%0d]: got tick %0d lat %0d expected tick %0d lat 0",
                     f, w.tk, w.lat, t0 + 8 + 16 * (len + int'(pen) + 1));
          end
        end
      end
      wait_ticks($urandom_range(0, 3));
    end
  endtask

  task automatic test_quiet_flags();
    n_checks++;
    if (stray_flags != 0 || oe_maxrun > 1) begin
      n_fail++;
      $display("FAIL quiet_flags: got %0d stray status cycles oe width %0d expected 0 and at most 1",
               stray_flags, oe_maxrun);
    end
  endtask

  initial begin
    rx_if.rcvr_fifo_full = 1'b0;
    test_reset();
    test_8n1();
    test_parity5();
    test_framing();
    test_break();
    test_glitch_overrun();
    test_reset_midframe();
    test_random();
    test_quiet_flags();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Synthesizable UART receive deframer, the far end of the serial line that the TX-side monitor checks. Oversamples sRX using a 16x baud-tick enable and strips start, parity and stop bits. Delivers right-justified characters with PE/FE/BI/OE status to the RX FIFO write port. Sits between the pad/loopback mux and the RCVR FIFO, in the PCLK domain.

Parameters:
PDATA_WIDTH, 8, maximum character width (bits)
BAUD_SAMPLE_CYCLES, 16, baud ticks per bit period

Ports:
PCLK  in  1  system clock
PRESETn  in  1  asynchronous active-low reset
baud_tick  in  1  one-PCLK pulse at 16x baud rate
sRX  in  1  serial input; asynchronous; idle high
lcr_charl  in  2  character length: 00=5, 01=6, 10=7, 11=8
lcr_stop  in  1  stop-bit select; receiver checks only the first stop bit
lcr_par_en  in  1  parity enable
lcr_par_sel  in  1  1=even parity, 0=odd parity
rcvr_fifo_full  in  1  RX FIFO cannot accept a write
rx_wr  out  1  one-cycle FIFO write strobe
rx_data  out  PDATA_WIDTH  received character, LSB at bit 0, unused upper bits 0
rx_pe  out  1  parity error, valid with rx_wr
rx_fe  out  1  framing error, valid with rx_wr
rx_bi  out  1  break indicator, valid with rx_wr
rx_oe  out  1  one-cycle overrun pulse
rx_busy  out  1  high from validated start bit until return to IDLE

Behaviour:
- Reset (async, PRESETn low): state=IDLE, tick counter=0, shift register=0. All outputs 0. Synchronizer flops reset to 1. Takes effect mid-frame; the partial character is discarded.
- sRX passes through a 2-flop synchronizer. Falling-edge detect works on the synchronized value.
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: a falling edge clears the tick counter and moves to START.
- Tick counter increments only on baud_tick. A bit is sampled at mid-bit.
- START: sample on the 8th tick. If low: latch LCR fields, set rx_busy, clear the counter, go to DATA. If high: false start, return to IDLE with no write.
- LCR changes during a frame are ignored until the next start bit.
- DATA: sample every 16th tick and shift in LSB first. After N bits (N=5..8 from latched charl), go to PARITY if par_en, else STOP.
- PARITY: sample at the 16th tick.
  - even: expected bit = ^data.
  - odd: expected bit = ~^data.
  - Mismatch sets pe.
- STOP: sample at the 16th tick. fe=1 if the sample is low.
  - The frame completes in that cycle: rx_wr=1 for one PCLK, with rx_data/pe/fe/bi valid.
  - Latency: the write strobe comes 1 PCLK after the baud_tick that samples the first stop bit.
- Break: data all zero, parity sample zero (or parity disabled) and stop sample zero gives bi=1 and fe=1. After the write, go to BRK_WAIT and stay until synchronized sRX=1, then IDLE.
- Normal completion returns to IDLE from mid-stop, so a start edge arriving within the stop bit is accepted.
- Overrun: if rcvr_fifo_full=1 in the completion cycle, rx_wr stays 0 and rx_oe pulses 1 cycle. The character is dropped.
- rx_pe/rx_fe/rx_bi are 0 whenever rx_wr=0.
- baud_tick held low freezes the FSM without losing state.

Optional Feature:
Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: every sample point (start, data, parity, stop) takes the 2-of-3 majority of the synchronized sRX at ticks 7, 8 and 9 (start) or 15, 16 and 17-equivalent. Implementation: samples at counts 7, 8, 9 in each bit window, with the decision at tick 9; all later windows are measured from that point.
- Undefined: single sample at tick 8 / tick 16 as above.
- Frame timing otherwise identical.

Decomposition:
- Package uart_pkg:
  - PDATA_WIDTH, BAUD_SAMPLE_CYCLES
  - charl_t enum (CHAR5..CHAR8)
  - rx_state_t enum
  - function charl_to_len
- Sub-module uart_rx_sync_edge: 2-flop synchronizer with reset-to-1, plus falling-edge pulse. Reused by break/loopback logic.

Test Plan:
- 8N1, char 0xA5, FIFO not full -> rx_wr once, rx_data=0xA5, pe=fe=bi=0, rx_busy drops at mid-stop.
- 5-bit even parity, char 5'h13, parity bit 1 -> rx_data=0x13, pe=0. Same frame with parity bit 0 -> pe=1.
- 7O1, char 0x41, stop bit forced low -> rx_wr, rx_data=0x41, fe=1, bi=0.
- sRX low for 2 full frame times (8N1) -> one rx_wr with rx_data=0x00, bi=1, fe=1; no further writes until sRX high; next frame 0x3C is received correctly.
- 300-PCLK-wide low glitch (< 8 ticks at div=64) -> no rx_wr, state back in IDLE. Then 0x5A with rcvr_fifo_full=1 -> rx_wr=0, rx_oe pulse of 1 cycle.
- PRESETn asserted after bit 3 of 0xFF -> all outputs 0 immediately; next frame 0x81 is received correctly.
